// File: rtl/nandn_cmd_sweeper_if.sv
// Command/response bus for nandn_cmd_sweeper, plus the applied vector and gate result.
interface nandn_cmd_sweeper_if #(
    parameter int unsigned N_IN = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_code;
    logic [N_IN-1:0] cmd_arg;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2:0]      rsp_code;
    logic [N_IN:0]   rsp_data;
    logic [N_IN-1:0] vec_out;
    logic            gate_out;

    modport master (
        output cmd_valid, cmd_code, cmd_arg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_code, rsp_data, vec_out, gate_out
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_arg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_code, rsp_data, vec_out, gate_out
    );
endinterface

// File: rtl/nandn_cmd_sweeper.sv
// N-input reduction-gate evaluator with single-vector EVAL and an exhaustive
// truth-table SWEEP that counts true outputs, behind a command/response handshake.
module nandn_cmd_sweeper #(
    parameter int unsigned N_IN     = 2,
    parameter int unsigned HOLD_CYC = 1
) (
    input logic               clk,
    input logic               rst_n,
    nandn_cmd_sweeper_if.slave bus
);
    localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_RESP} state_e;
    typedef enum logic [1:0] {M_NAND, M_NOR, M_AND, M_OR} mode_e;
    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_SET_MODE = 3'd1,
        OP_EVAL     = 3'd2,
        OP_SWEEP    = 3'd3
    } op_e;
    typedef enum logic [2:0] {
        RSP_NOP      = 3'd0,
        RSP_ERROR    = 3'd5,
        RSP_RESPONSE = 3'd7
    } rsp_e;

    state_e          state_q;
    mode_e           mode_q;
    logic [N_IN-1:0] vec_q;
    logic [HW-1:0]   hold_q;
    logic [N_IN:0]   cnt_q;
    logic [N_IN:0]   cnt_d;
    rsp_e            rsp_code_q;
    logic [N_IN:0]   rsp_data_q;

    function automatic logic gate_fn(input mode_e m, input logic [N_IN-1:0] v);
        case (m)
            M_NAND:  return ~&v;
            M_NOR:   return ~|v;
            M_AND:   return &v;
            M_OR:    return |v;
            default: return ~&v;
        endcase
    endfunction

    assign bus.gate_out  = gate_fn(mode_q, vec_q);
    assign bus.vec_out   = vec_q;
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_data  = rsp_data_q;
    assign cnt_d         = cnt_q + (N_IN+1)'(bus.gate_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= M_NAND;
            vec_q      <= '0;
            hold_q     <= '0;
            cnt_q      <= '0;
            rsp_code_q <= RSP_NOP;
            rsp_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_code)
                            OP_NOP: ;
                            OP_SET_MODE: begin
                                mode_q     <= mode_e'(bus.cmd_arg[1:0]);
                                rsp_code_q <= RSP_RESPONSE;
                                rsp_data_q <= (N_IN+1)'(bus.cmd_arg[1:0]);
                                state_q    <= S_RESP;
                            end
                            OP_EVAL: begin
                                vec_q      <= bus.cmd_arg;
                                rsp_code_q <= RSP_RESPONSE;
                                rsp_data_q <= (N_IN+1)'(gate_fn(mode_q, bus.cmd_arg));
                                state_q    <= S_RESP;
                            end
                            OP_SWEEP: begin
                                vec_q   <= '0;
                                hold_q  <= '0;
                                cnt_q   <= '0;
                                state_q <= S_SWEEP;
                            end
                            default: begin
                                rsp_code_q <= RSP_ERROR;
                                rsp_data_q <= '0;
                                state_q    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_SWEEP: begin
                    hold_q <= hold_q + 1'b1;
                    // Score each vector on its last hold cycle; the all-ones vector ends the sweep
                    if (hold_q == HW'(HOLD_CYC - 1)) begin
                        cnt_q <= cnt_d;
                        if (&vec_q) begin
                            rsp_code_q <= RSP_RESPONSE;
                            rsp_data_q <= cnt_d;
                            state_q    <= S_RESP;
                        end else begin
                            vec_q  <= vec_q + 1'b1;
                            hold_q <= '0;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nandn_cmd_sweeper.sv
// Directed bench: three sweeper instances (N2/H1, N2/H3, N3/H1) sharing opcode,
// operand and rsp_ready drives, each with its own cmd_valid.
module tb_nandn_cmd_sweeper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] vld;
    logic [2:0] code;
    logic [2:0] arg;
    logic       rr;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    nandn_cmd_sweeper_if #(.N_IN(2)) ifa ();
    nandn_cmd_sweeper_if #(.N_IN(2)) ifb ();
    nandn_cmd_sweeper_if #(.N_IN(3)) ifc ();

    nandn_cmd_sweeper #(.N_IN(2), .HOLD_CYC(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    nandn_cmd_sweeper #(.N_IN(2), .HOLD_CYC(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    nandn_cmd_sweeper #(.N_IN(3), .HOLD_CYC(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    assign ifa.cmd_valid = vld[0];
    assign ifb.cmd_valid = vld[1];
    assign ifc.cmd_valid = vld[2];
    assign ifa.cmd_code  = code;
    assign ifb.cmd_code  = code;
    assign ifc.cmd_code  = code;
    assign ifa.cmd_arg   = arg[1:0];
    assign ifb.cmd_arg   = arg[1:0];
    assign ifc.cmd_arg   = arg;
    assign ifa.rsp_ready = rr;
    assign ifb.rsp_ready = rr;
    assign ifc.rsp_ready = rr;

    logic       rdy  [3];
    logic       rv   [3];
    logic       gout [3];
    logic [2:0] rcode[3];
    logic [2:0] vec  [3];
    logic [3:0] rdata[3];

    always_comb begin
        rdy[0] = ifa.cmd_ready;  rdy[1] = ifb.cmd_ready;  rdy[2] = ifc.cmd_ready;
        rv[0]  = ifa.rsp_valid;  rv[1]  = ifb.rsp_valid;  rv[2]  = ifc.rsp_valid;
        gout[0] = ifa.gate_out;  gout[1] = ifb.gate_out;  gout[2] = ifc.gate_out;
        rcode[0] = ifa.rsp_code; rcode[1] = ifb.rsp_code; rcode[2] = ifc.rsp_code;
        vec[0] = {1'b0, ifa.vec_out};
        vec[1] = {1'b0, ifb.vec_out};
        vec[2] = ifc.vec_out;
        rdata[0] = {1'b0, ifa.rsp_data};
        rdata[1] = {1'b0, ifb.rsp_data};
        rdata[2] = ifc.rsp_data;
    end

    // Offer one command to instance k; returns 1 ns after the accepting edge.
    task automatic issue(input int k, input logic [2:0] c, input logic [2:0] a);
        @(negedge clk);
        code   = c;
        arg    = a;
        vld[k] = 1'b1;
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output int cyc);
        cyc = 0;
        while (!rv[k] && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld   = '0;
        code  = '0;
        arg   = '0;
        rr    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rdy[k], rv[k], rcode[k], rdata[k], vec[k], gout[k]} !== 13'b1_0_000_0000_000_1) begin
                failures++;
                $display("FAIL reset[%0d] got=%b exp=%b", k,
                         {rdy[k], rv[k], rcode[k], rdata[k], vec[k], gout[k]}, 13'b1_0_000_0000_000_1);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_eval();
        logic [3:0] exp_d [4];
        exp_d = '{4'd1, 4'd1, 4'd1, 4'd0};
        for (int i = 0; i < 4; i++) begin
            issue(0, 3'd2, 3'(i));
            checks++;
            if ({rv[0], rcode[0], rdata[0], vec[0], rdy[0]} !== {1'b1, 3'd7, exp_d[i], 3'(i), 1'b0}) begin
                failures++;
                $display("FAIL eval[%0d] {rv,code,data,vec,rdy} got=%b exp=%b", i,
                         {rv[0], rcode[0], rdata[0], vec[0], rdy[0]}, {1'b1, 3'd7, exp_d[i], 3'(i), 1'b0});
            end
            step();
            checks++;
            if ({rv[0], rdy[0]} !== 2'b01) begin
                failures++;
                $display("FAIL eval_done[%0d] {rv,rdy} got=%b exp=01", i, {rv[0], rdy[0]});
            end
        end
    endtask

    task automatic test_sweep();
        int cyc;
        issue(0, 3'd3, 3'd0);
        checks++;
        if ({rv[0], vec[0]} !== 4'b0_000) begin
            failures++;
            $display("FAIL sweep_start {rv,vec} got=%b exp=0000", {rv[0], vec[0]});
        end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if ({rv[0], vec[0]} !== {1'b0, 3'(i)}) begin
                failures++;
                $display("FAIL sweep_step[%0d] {rv,vec} got=%b exp=%b", i, {rv[0], vec[0]}, {1'b0, 3'(i)});
            end
        end
        step();
        checks++;
        if ({rv[0], rcode[0], rdata[0], vec[0]} !== {1'b1, 3'd7, 4'd3, 3'd3}) begin
            failures++;
            $display("FAIL sweep_rsp {rv,code,data,vec} got=%b exp=%b",
                     {rv[0], rcode[0], rdata[0], vec[0]}, {1'b1, 3'd7, 4'd3, 3'd3});
        end
        step();
        issue(1, 3'd3, 3'd0);
        wait_rsp(1, cyc);
        checks++;
        if (cyc !== 12) begin
            failures++;
            $display("FAIL sweep_hold3_latency got=%0d exp=12", cyc);
        end
        checks++;
        if ({rcode[1], rdata[1]} !== {3'd7, 4'd3}) begin
            failures++;
            $display("FAIL sweep_hold3_rsp {code,data} got=%b exp=%b", {rcode[1], rdata[1]}, {3'd7, 4'd3});
        end
        step();
    endtask

    task automatic test_modes();
        int         cyc;
        logic [2:0] modes [4];
        logic [3:0] exp_c [4];
        modes = '{3'd1, 3'd2, 3'd3, 3'd0};
        exp_c = '{4'd1, 4'd1, 4'd7, 4'd7};
        for (int i = 0; i < 4; i++) begin
            issue(2, 3'd1, modes[i]);
            checks++;
            if ({rv[2], rcode[2], rdata[2]} !== {1'b1, 3'd7, {1'b0, modes[i]}}) begin
                failures++;
                $display("FAIL set_mode[%0d] {rv,code,data} got=%b exp=%b", i,
                         {rv[2], rcode[2], rdata[2]}, {1'b1, 3'd7, {1'b0, modes[i]}});
            end
            step();
            issue(2, 3'd3, 3'd0);
            wait_rsp(2, cyc);
            checks++;
            if (cyc !== 8) begin
                failures++;
                $display("FAIL mode_sweep_latency[%0d] got=%0d exp=8", i, cyc);
            end
            checks++;
            if ({rcode[2], rdata[2]} !== {3'd7, exp_c[i]}) begin
                failures++;
                $display("FAIL mode_sweep_count[%0d] {code,data} got=%b exp=%b", i,
                         {rcode[2], rdata[2]}, {3'd7, exp_c[i]});
            end
            step();
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        rr = 1'b0;
        issue(0, 3'd2, 3'd3);
        checks++;
        if ({rv[0], rcode[0], rdata[0], vec[0]} !== {1'b1, 3'd7, 4'd0, 3'd3}) begin
            failures++;
            $display("FAIL stall_first {rv,code,data,vec} got=%b exp=%b",
                     {rv[0], rcode[0], rdata[0], vec[0]}, {1'b1, 3'd7, 4'd0, 3'd3});
        end
        @(negedge clk);
        code   = 3'd2;
        arg    = 3'd1;
        vld[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({rv[0], rcode[0], rdata[0], rdy[0], vec[0]} !== {1'b1, 3'd7, 4'd0, 1'b0, 3'd3}) begin
                failures++;
                $display("FAIL stall_hold[%0d] {rv,code,data,rdy,vec} got=%b exp=%b", i,
                         {rv[0], rcode[0], rdata[0], rdy[0], vec[0]}, {1'b1, 3'd7, 4'd0, 1'b0, 3'd3});
            end
        end
        @(negedge clk);
        rr = 1'b1;
        step();
        checks++;
        if ({rv[0], rdy[0], vec[0]} !== {1'b0, 1'b1, 3'd3}) begin
            failures++;
            $display("FAIL stall_handshake {rv,rdy,vec} got=%b exp=%b", {rv[0], rdy[0], vec[0]}, {1'b0, 1'b1, 3'd3});
        end
        step();
        checks++;
        if ({rv[0], rdata[0], vec[0]} !== {1'b1, 4'd1, 3'd1}) begin
            failures++;
            $display("FAIL stall_next_cmd {rv,data,vec} got=%b exp=%b", {rv[0], rdata[0], vec[0]}, {1'b1, 4'd1, 3'd1});
        end
        @(negedge clk);
        vld[0] = 1'b0;
        step();
    endtask

    task automatic test_illegal_nop();
        issue(0, 3'd1, 3'd2);
        step();
        issue(0, 3'd5, 3'd0);
        checks++;
        if ({rv[0], rcode[0], rdata[0], vec[0], gout[0]} !== {1'b1, 3'd5, 4'd0, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL illegal {rv,code,data,vec,gate} got=%b exp=%b",
                     {rv[0], rcode[0], rdata[0], vec[0], gout[0]}, {1'b1, 3'd5, 4'd0, 3'd1, 1'b0});
        end
        step();
        issue(0, 3'd0, 3'd3);
        checks++;
        if ({rv[0], rdy[0], vec[0]} !== {1'b0, 1'b1, 3'd1}) begin
            failures++;
            $display("FAIL nop {rv,rdy,vec} got=%b exp=%b", {rv[0], rdy[0], vec[0]}, {1'b0, 1'b1, 3'd1});
        end
        repeat (3) step();
        checks++;
        if ({rv[0], rdy[0]} !== 2'b01) begin
            failures++;
            $display("FAIL nop_quiet {rv,rdy} got=%b exp=01", {rv[0], rdy[0]});
        end
        issue(0, 3'd2, 3'd3);
        checks++;
        if ({rv[0], rcode[0], rdata[0]} !== {1'b1, 3'd7, 4'd1}) begin
            failures++;
            $display("FAIL mode_kept {rv,code,data} got=%b exp=%b", {rv[0], rcode[0], rdata[0]}, {1'b1, 3'd7, 4'd1});
        end
        step();
    endtask

    task automatic test_reset_mid_sweep();
        int stale;
        issue(0, 3'd1, 3'd3);
        step();
        issue(0, 3'd3, 3'd0);
        step();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        checks++;
        if ({vec[0], rv[0], gout[0], rdy[0]} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL abort {vec,rv,gate,rdy} got=%b exp=%b", {vec[0], rv[0], gout[0], rdy[0]}, {3'd0, 1'b0, 1'b1, 1'b1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rv[0]) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL abort_stale_rsp got=%0d exp=0", stale);
        end
        issue(0, 3'd2, 3'd3);
        checks++;
        if ({rv[0], rcode[0], rdata[0]} !== {1'b1, 3'd7, 4'd0}) begin
            failures++;
            $display("FAIL abort_mode_nand {rv,code,data} got=%b exp=%b", {rv[0], rcode[0], rdata[0]}, {1'b1, 3'd7, 4'd0});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_eval();
        test_sweep();
        test_modes();
        test_stall();
        test_illegal_nop();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
